// File: rtl/wb_ddr_line_reader_pkg.sv
// Shared constants and state encoding for the Wishbone-to-DDR single-line read buffer.
package wb_ddr_line_reader_pkg;

   localparam int DEF_LINE_WORDS_LOG2 = 3;
   localparam int DEF_LOCAL_AW        = 22;
   localparam int LINE_WORDS          = 1 << DEF_LINE_WORDS_LOG2;
   localparam int BURST_SIZE          = LINE_WORDS;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_HIT    = 3'd1,
      RD_OUT    = 3'd2,
      FILL_REQ  = 3'd3,
      FILL_WAIT = 3'd4,
      WR_REQ    = 3'd5
   } state_t;

   function automatic int line_words(input int log2);
      return 1 << log2;
   endfunction

endpackage

// File: rtl/dpram_generic.sv
// Dual-port RAM with per-byte write enables on both ports and a registered read on port a.
module dpram_generic #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic [ADDR_WIDTH-1:0]   addr_a,
   input  logic [DATA_WIDTH-1:0]   din_a,
   input  logic [DATA_WIDTH/8-1:0] we_a,
   output logic [DATA_WIDTH-1:0]   dout_a,
   input  logic [ADDR_WIDTH-1:0]   addr_b,
   input  logic [DATA_WIDTH-1:0]   din_b,
   input  logic [DATA_WIDTH/8-1:0] we_b
);

   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   // Read-before-write on port a; port b wins a same-byte collision.
   always_ff @(posedge clk) begin
      dout_a <= mem[addr_a];
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
         if (we_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
         if (we_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
      end
   end

endmodule

// File: rtl/wb_ddr_line_reader.sv
// Wishbone classic slave with a one-line read buffer in front of the DDR local port;
// read misses burst-fill the line, writes go straight through to DDR.
module wb_ddr_line_reader
   import wb_ddr_line_reader_pkg::*;
#(
   parameter int LINE_WORDS_LOG2 = DEF_LINE_WORDS_LOG2,
   parameter int LOCAL_AW        = DEF_LOCAL_AW
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   input  logic [31:0]                wb_adr_i,
   input  logic [31:0]                wb_dat_i,
   input  logic [3:0]                 wb_sel_i,
   input  logic                       wb_we_i,
   input  logic                       wb_cyc_i,
   input  logic                       wb_stb_i,
   output logic [31:0]                wb_dat_o,
   output logic                       wb_ack_o,
   output logic [LOCAL_AW-1:0]        local_address,
   output logic                       local_read_req,
   output logic                       local_write_req,
   output logic                       local_burstbegin,
   output logic [LINE_WORDS_LOG2:0]   local_size,
   output logic [3:0]                 local_be,
   output logic [31:0]                local_wdata,
   input  logic                       local_ready,
   input  logic [31:0]                local_rdata,
   input  logic                       local_rdata_valid
);

   localparam int LW     = line_words(LINE_WORDS_LOG2);
   localparam int TAG_W  = 30 - LINE_WORDS_LOG2;
   localparam int SIZE_W = LINE_WORDS_LOG2 + 1;

   state_t                     state, state_nx;
   logic                       line_valid;
   logic [TAG_W-1:0]           line_tag;
   logic [29:0]                cap_wadr;
   logic [31:0]                cap_dat;
   logic [3:0]                 cap_sel;
   logic [LINE_WORDS_LOG2-1:0] beat_cnt;
   logic                       reread;

   logic                       req;
   logic                       req_hit;
   logic                       wr_hit;
   logic                       last_beat;
   logic [LINE_WORDS_LOG2-1:0] buf_addr_a;
   logic [3:0]                 buf_we_a;
   logic [3:0]                 buf_we_b;
   logic [31:0]                buf_dout_a;
   logic                       unused_adr;

   assign unused_adr = ^wb_adr_i[1:0];

   assign req       = wb_cyc_i & wb_stb_i;
   assign req_hit   = line_valid && (wb_adr_i[31:LINE_WORDS_LOG2+2] == line_tag);
   assign wr_hit    = line_valid && (cap_wadr[29:LINE_WORDS_LOG2] == line_tag);
   assign last_beat = local_rdata_valid && (beat_cnt == LINE_WORDS_LOG2'(LW-1));

   // In IDLE the buffer is addressed straight from the bus so a hit has data one cycle later.
   assign buf_addr_a = (state == IDLE) ? wb_adr_i[LINE_WORDS_LOG2+1:2]
                                       : cap_wadr[LINE_WORDS_LOG2-1:0];
   assign buf_we_a   = (state == WR_REQ && local_ready && wr_hit) ? cap_sel : 4'h0;
   assign buf_we_b   = (state == FILL_WAIT && local_rdata_valid) ? 4'hF : 4'h0;

   dpram_generic #(
      .ADDR_WIDTH (LINE_WORDS_LOG2),
      .DATA_WIDTH (32)
   ) u_line_buf (
      .clk    (wb_clk_i),
      .addr_a (buf_addr_a),
      .din_a  (cap_dat),
      .we_a   (buf_we_a),
      .dout_a (buf_dout_a),
      .addr_b (beat_cnt),
      .din_b  (local_rdata),
      .we_b   (buf_we_b)
   );

   // RD_OUT is also the ack cycle for writes; wb_dat_o is simply left unchanged then.
   always_comb begin
      state_nx         = state;
      wb_ack_o         = 1'b0;
      local_read_req   = 1'b0;
      local_write_req  = 1'b0;
      local_burstbegin = 1'b0;
      local_size       = '0;
      local_be         = '0;
      local_wdata      = '0;
      local_address    = '0;
      case (state)
         IDLE: begin
            if (req) begin
               if (wb_we_i)      state_nx = WR_REQ;
               else if (req_hit) state_nx = RD_HIT;
               else              state_nx = FILL_REQ;
            end
         end
         RD_HIT: begin
            if (!reread) state_nx = RD_OUT;
         end
         RD_OUT: begin
            wb_ack_o = wb_cyc_i;
            state_nx = IDLE;
         end
         FILL_REQ: begin
            local_read_req   = 1'b1;
            local_burstbegin = 1'b1;
            local_size       = SIZE_W'(LW);
            local_address    = {cap_wadr[LOCAL_AW-1:LINE_WORDS_LOG2], {LINE_WORDS_LOG2{1'b0}}};
            if (local_ready) state_nx = FILL_WAIT;
         end
         FILL_WAIT: begin
            if (last_beat) state_nx = RD_HIT;
         end
         WR_REQ: begin
            local_write_req  = 1'b1;
            local_burstbegin = 1'b1;
            local_size       = SIZE_W'(1);
            local_be         = cap_sel;
            local_wdata      = cap_dat;
            local_address    = cap_wadr[LOCAL_AW-1:0];
            if (local_ready) state_nx = RD_OUT;
         end
         default: state_nx = IDLE;
      endcase
   end

   // After a fill the word just written may be the one requested, so RD_HIT spends one
   // extra cycle re-reading the buffer before registering the output.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         line_valid <= 1'b0;
         line_tag   <= '0;
         cap_wadr   <= '0;
         cap_dat    <= '0;
         cap_sel    <= '0;
         beat_cnt   <= '0;
         reread     <= 1'b0;
         wb_dat_o   <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req) begin
            cap_wadr <= wb_adr_i[31:2];
            cap_dat  <= wb_dat_i;
            cap_sel  <= wb_sel_i;
            if (!wb_we_i && !req_hit) line_valid <= 1'b0;
         end
         if (state == FILL_REQ) begin
            beat_cnt <= '0;
         end else if (state == FILL_WAIT && local_rdata_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (state == FILL_WAIT && last_beat) begin
            line_tag   <= cap_wadr[29:LINE_WORDS_LOG2];
            line_valid <= 1'b1;
            reread     <= 1'b1;
         end else if (state == RD_HIT) begin
            reread <= 1'b0;
         end
         if (state == RD_HIT && !reread) wb_dat_o <= buf_dout_a;
      end
   end

endmodule

// File: tb/tb_wb_ddr_line_reader.sv
// Directed bench for wb_ddr_line_reader: a transaction-level model predicts request windows,
// ack cycles and read data, and a negedge process compares the DUT against it every cycle.
module tb_wb_ddr_line_reader;
   import wb_ddr_line_reader_pkg::*;

   logic        clk;
   logic        wb_rst_i;
   logic [31:0] wb_adr_i, wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i, wb_cyc_i, wb_stb_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic [21:0] local_address;
   logic        local_read_req, local_write_req, local_burstbegin;
   logic [3:0]  local_size;
   logic [3:0]  local_be;
   logic [31:0] local_wdata;
   logic        local_ready;
   logic [31:0] local_rdata;
   logic        local_rdata_valid;

   wb_ddr_line_reader #(.LINE_WORDS_LOG2(3), .LOCAL_AW(22)) dut (
      .wb_clk_i          (clk),
      .wb_rst_i          (wb_rst_i),
      .wb_adr_i          (wb_adr_i),
      .wb_dat_i          (wb_dat_i),
      .wb_sel_i          (wb_sel_i),
      .wb_we_i           (wb_we_i),
      .wb_cyc_i          (wb_cyc_i),
      .wb_stb_i          (wb_stb_i),
      .wb_dat_o          (wb_dat_o),
      .wb_ack_o          (wb_ack_o),
      .local_address     (local_address),
      .local_read_req    (local_read_req),
      .local_write_req   (local_write_req),
      .local_burstbegin  (local_burstbegin),
      .local_size        (local_size),
      .local_be          (local_be),
      .local_wdata       (local_wdata),
      .local_ready       (local_ready),
      .local_rdata       (local_rdata),
      .local_rdata_valid (local_rdata_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;
   int cycle_no = 0;
   always @(posedge clk) cycle_no <= cycle_no + 1;

   // Model state: the buffered line and a sparse DDR image
   bit          m_valid = 1'b0;
   logic [26:0] m_tag;
   logic [31:0] m_buf [LINE_WORDS];
   logic [31:0] ddr_mem [logic [21:0]];

   // Expectation windows for the compare process
   bit          checking = 1'b0;
   int          exp_ack_cycle = -1;
   bit          exp_ack_rd;
   logic [31:0] exp_rdata;
   int          rd_from = -1, rd_to = -1;
   logic [21:0] exp_rd_addr;
   int          wr_from = -1, wr_to = -1;
   logic [21:0] exp_wr_addr;
   logic [3:0]  exp_be;
   logic [31:0] exp_wdata;

   // Observations used by the hand-computed literal checks
   int          fill_accepts = 0;
   logic [21:0] last_fill_addr = '0;
   logic [21:0] last_wr_addr = '0;
   logic [3:0]  last_wr_be = '0;
   logic [31:0] last_ack_data = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle_no);
      end
   endtask

   function automatic logic [31:0] ddr_rd(input logic [21:0] a);
      if (ddr_mem.exists(a)) return ddr_mem[a];
      if (a[21:3] == 19'h80) return 32'h0000_00A0 + 32'(a[2:0]);
      return 32'hC000_0000 | 32'(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   always @(negedge clk) begin
      if (checking) begin
         bit in_rd, in_wr, want_ack;
         in_rd    = (cycle_no >= rd_from) && (cycle_no <= rd_to);
         in_wr    = (cycle_no >= wr_from) && (cycle_no <= wr_to);
         want_ack = (cycle_no == exp_ack_cycle);
         checkOutput("ack", 32'(wb_ack_o), 32'(want_ack));
         checkOutput("read_req", 32'(local_read_req), 32'(in_rd));
         checkOutput("write_req", 32'(local_write_req), 32'(in_wr));
         checkOutput("burstbegin", 32'(local_burstbegin), 32'(in_rd | in_wr));
         if (in_rd) begin
            checkOutput("rd_addr", 32'(local_address), 32'(exp_rd_addr));
            checkOutput("rd_size", 32'(local_size), 32'(BURST_SIZE));
         end else if (in_wr) begin
            checkOutput("wr_addr", 32'(local_address), 32'(exp_wr_addr));
            checkOutput("wr_size", 32'(local_size), 32'd1);
            checkOutput("wr_be", 32'(local_be), 32'(exp_be));
            checkOutput("wr_data", local_wdata, exp_wdata);
         end else begin
            checkOutput("idle_local_outs",
                        32'(|{local_address, local_be, local_wdata, local_size}), 32'd0);
         end
         if (want_ack && exp_ack_rd) checkOutput("rdata", wb_dat_o, exp_rdata);
         if (local_read_req && local_ready) begin
            fill_accepts++;
            last_fill_addr = local_address;
         end
         if (local_write_req && local_ready) begin
            last_wr_addr = local_address;
            last_wr_be   = local_be;
         end
         if (wb_ack_o) last_ack_data = wb_dat_o;
      end
   end

   // One Wishbone transaction plus the DDR controller's side of it, all on a precomputed
   // timeline. cyc_drop_beat/rst_beat < 0 disables that event; b2b keeps stb high afterwards.
   task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input int ready_dly, input int gap,
                                input int cyc_drop_beat, input int rst_beat, input bit b2b);
      int          n, acc, last, rst_cyc;
      int          beat_cyc [LINE_WORDS];
      logic [31:0] beat_dat [LINE_WORDS];
      logic [21:0] wa;
      int          w;
      bit          hit;
      n       = cycle_no;
      wa      = adr[23:2];
      w       = int'(adr[4:2]);
      hit     = m_valid && (m_tag == adr[31:5]);
      acc     = -1;
      rst_cyc = -1;
      for (int i = 0; i < LINE_WORDS; i++) beat_cyc[i] = -1;
      exp_ack_cycle = -1;
      rd_from = -1; rd_to = -1;
      wr_from = -1; wr_to = -1;

      wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;

      if (we) begin
         acc = n + 1 + ready_dly;
         wr_from = n + 1; wr_to = acc;
         exp_wr_addr = wa; exp_be = sel; exp_wdata = dat;
         exp_ack_rd = 1'b0;
         exp_ack_cycle = acc + 1;
         last = acc + 1;
         ddr_mem[wa] = merge(ddr_rd(wa), dat, sel);
         if (hit) m_buf[w] = merge(m_buf[w], dat, sel);
      end else if (hit) begin
         exp_ack_rd = 1'b1;
         exp_rdata = m_buf[w];
         exp_ack_cycle = n + 2;
         last = n + 2;
      end else begin
         acc = n + 1 + ready_dly;
         rd_from = n + 1; rd_to = acc;
         exp_rd_addr = {wa[21:3], 3'b000};
         for (int i = 0; i < LINE_WORDS; i++) begin
            beat_cyc[i] = acc + 1 + i * (gap + 1);
            beat_dat[i] = ddr_rd({wa[21:3], 3'(i)});
            m_buf[i]    = beat_dat[i];
         end
         exp_ack_rd = 1'b1;
         exp_rdata  = m_buf[w];
         last = beat_cyc[LINE_WORDS-1] + 3;
         m_valid = 1'b1;
         m_tag   = adr[31:5];
         if (cyc_drop_beat < 0 && rst_beat < 0) exp_ack_cycle = last;
         if (rst_beat >= 0) begin
            rst_cyc = beat_cyc[rst_beat] + 1;
            last    = rst_cyc;
            m_valid = 1'b0;
         end
      end

      for (int c = n; c <= last; c++) begin
         local_ready       = (c == acc);
         local_rdata_valid = 1'b0;
         local_rdata       = 32'h0;
         for (int i = 0; i < LINE_WORDS; i++) begin
            if (c == beat_cyc[i] && (rst_cyc < 0 || c < rst_cyc)) begin
               local_rdata_valid = 1'b1;
               local_rdata       = beat_dat[i];
            end
         end
         if (cyc_drop_beat >= 0 && c >= beat_cyc[cyc_drop_beat]) begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b0;
         end
         wb_rst_i = (c == rst_cyc);
         @(posedge clk);
         #1;
      end

      local_ready = 1'b0;
      local_rdata_valid = 1'b0;
      if (rst_cyc >= 0) begin
         checkOutput("rst_ctrl_outs", 32'({wb_ack_o, local_read_req, local_write_req,
                                           local_burstbegin, local_size, local_be}), 32'd0);
         checkOutput("rst_address", 32'(local_address), 32'd0);
         checkOutput("rst_wdata", local_wdata, 32'd0);
         checkOutput("rst_dat_o", wb_dat_o, 32'd0);
      end
      wb_rst_i = 1'b0;
      if (!b2b) begin
         wb_cyc_i = 1'b0;
         wb_stb_i = 1'b0;
         wb_we_i  = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int fa;
      wb_rst_i = 1'b1;
      wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      local_ready = 1'b0; local_rdata = '0; local_rdata_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ctrl_outs", 32'({wb_ack_o, local_read_req, local_write_req,
                                          local_burstbegin, local_size, local_be}), 32'd0);
      checkOutput("reset_address", 32'(local_address), 32'd0);
      checkOutput("reset_wdata", local_wdata, 32'd0);
      checkOutput("reset_dat_o", wb_dat_o, 32'd0);
      wb_rst_i = 1'b0;
      @(posedge clk);
      #1;
      checking = 1'b1;
      $display("[TB] cold read miss");
      fa = fill_accepts;
      applyStimulus(1'b0, 32'h0000_1004, 32'h0, 4'hF, 2, 0, -1, -1, 1'b0);
      checkOutput("cold_fill_count", 32'(fill_accepts - fa), 32'd1);
      checkOutput("cold_fill_addr", 32'(last_fill_addr), 32'h400);
      checkOutput("cold_data", last_ack_data, 32'h0000_00A1);

      $display("[TB] read hit");
      fa = fill_accepts;
      applyStimulus(1'b0, 32'h0000_101C, 32'h0, 4'hF, 0, 0, -1, -1, 1'b0);
      checkOutput("hit_no_fill", 32'(fill_accepts - fa), 32'd0);
      checkOutput("hit_data", last_ack_data, 32'h0000_00A7);

      $display("[TB] write hit");
      applyStimulus(1'b1, 32'h0000_1008, 32'h1234_5678, 4'b0011, 0, 0, -1, -1, 1'b0);
      checkOutput("wr_hit_addr", 32'(last_wr_addr), 32'h402);
      checkOutput("wr_hit_be", 32'(last_wr_be), 32'h3);
      fa = fill_accepts;
      applyStimulus(1'b0, 32'h0000_1008, 32'h0, 4'hF, 0, 0, -1, -1, 1'b0);
      checkOutput("wr_hit_readback", last_ack_data, 32'h0000_5678);
      checkOutput("wr_hit_no_fill", 32'(fill_accepts - fa), 32'd0);

      $display("[TB] write miss then read");
      applyStimulus(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 1, 0, -1, -1, 1'b0);
      checkOutput("wr_miss_addr", 32'(last_wr_addr), 32'h800);
      fa = fill_accepts;
      applyStimulus(1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, 0, -1, -1, 1'b0);
      checkOutput("line_kept_data", last_ack_data, 32'h0000_00A0);
      checkOutput("line_kept_no_fill", 32'(fill_accepts - fa), 32'd0);
      applyStimulus(1'b0, 32'h0000_2000, 32'h0, 4'hF, 0, 0, -1, -1, 1'b0);
      checkOutput("miss_fill_addr", 32'(last_fill_addr), 32'h800);
      checkOutput("miss_fill_data", last_ack_data, 32'hDEAD_BEEF);

      $display("[TB] gapped beats with cyc drop, then back-to-back hits");
      applyStimulus(1'b0, 32'h0000_3010, 32'h0, 4'hF, 1, 2, 1, -1, 1'b0);
      fa = fill_accepts;
      applyStimulus(1'b0, 32'h0000_3000, 32'h0, 4'hF, 0, 0, -1, -1, 1'b1);
      applyStimulus(1'b0, 32'h0000_301C, 32'h0, 4'hF, 0, 0, -1, -1, 1'b0);
      checkOutput("gap_hit_data", last_ack_data, 32'hC000_0C07);
      checkOutput("gap_no_refill", 32'(fill_accepts - fa), 32'd0);

      $display("[TB] reset mid-fill");
      applyStimulus(1'b0, 32'h0000_4008, 32'h0, 4'hF, 0, 0, -1, 3, 1'b0);
      fa = fill_accepts;
      applyStimulus(1'b0, 32'h0000_4008, 32'h0, 4'hF, 1, 0, -1, -1, 1'b0);
      checkOutput("post_rst_refill", 32'(fill_accepts - fa), 32'd1);
      checkOutput("post_rst_fill_addr", 32'(last_fill_addr), 32'h1000);
      checkOutput("post_rst_data", last_ack_data, 32'hC000_1002);

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_ddr_line_reader.md
Name: wb_ddr_line_reader

Overview:
- Wishbone B3 classic slave that fronts the DDR local (Avalon-style) port with a single-line read buffer.
- Read hits are served from the buffer.
- Read misses issue one burst read and fill the buffer from returning beats.
- Writes are write-through single-beat DDR writes; a write that hits the buffered line also updates the buffer.
- Sits between the system Wishbone bus and the DDR controller local interface, on the read/fill side of the line buffer.

Parameters:
- LINE_WORDS_LOG2, 3, log2 of 32-bit words per line (8 words = 32 bytes).
- LOCAL_AW, 22, DDR local word-address width.

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- wb_adr_i  in  32  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  single-cycle acknowledge
- local_address  out  LOCAL_AW  DDR word address
- local_read_req  out  1  burst read request
- local_write_req  out  1  write request
- local_burstbegin  out  1  first cycle of a request
- local_size  out  LINE_WORDS_LOG2+1  beats in request
- local_be  out  4  write byte enables
- local_wdata  out  32  write data
- local_ready  in  1  controller accepts request when high
- local_rdata  in  32  read beat data
- local_rdata_valid  in  1  read beat strobe

Behaviour:
- Address split:
  - word index = wb_adr_i[LINE_WORDS_LOG2+1:2]
  - tag = wb_adr_i[31:LINE_WORDS_LOG2+2]
  - local_address = wb_adr_i[LOCAL_AW+1:2]; for fills, the low LINE_WORDS_LOG2 bits are forced to 0
- State: line_valid bit and tag register.
- Reset: state IDLE, line_valid=0; every output is 0.
- FSM states: IDLE, RD_HIT, RD_OUT, FILL_REQ, FILL_WAIT, WR_REQ.
- IDLE: request = wb_cyc_i & wb_stb_i, first sampled in cycle N.
  - Read, line_valid and tag match: go to RD_HIT.
  - Read miss: go to FILL_REQ.
  - Write: go to WR_REQ.
  - Address, data, sel and we are captured at N. Later wb_* input changes are ignored until ack.
- Read hit timing:
  - Buffer read issued at N; buffer data valid at N+1.
  - RD_OUT registers it into wb_dat_o; wb_ack_o=1 in cycle N+2 for exactly one cycle, then back to IDLE.
- FILL_REQ:
  - Drives local_read_req=1, local_burstbegin=1, local_size=1<<LINE_WORDS_LOG2, line-base address.
  - All held stable until local_ready is sampled 1, then go to FILL_WAIT.
  - line_valid is cleared on entry.
- FILL_WAIT:
  - Beat counter starts at 0.
  - Each local_rdata_valid writes local_rdata to buffer[counter], all 4 bytes, then counter++.
  - On the last beat (counter = LINE_WORDS-1): tag <= captured tag, line_valid <= 1, go to RD_HIT.
  - The ack therefore occurs 3 cycles after the last beat.
  - Beats may arrive with gaps; counter wraps are impossible by construction.
- WR_REQ:
  - Drives local_write_req=1, local_burstbegin=1, local_size=1, local_be=sel, local_wdata=data, full word address.
  - Held until local_ready is sampled 1.
  - In the accept cycle: if hit, buffer bytes with sel=1 are updated.
  - wb_ack_o=1 in the following cycle, then IDLE.
  - No write-allocate on miss.
- local_rdata_valid outside FILL_WAIT is ignored.
- wb_rst_i also resets the DDR controller, so no stale beats can follow reset.
- Reset mid-operation: abort to IDLE next edge; request outputs drop; line_valid=0.
- wb_cyc_i low after accept: the DDR transaction still completes (a fill still validates the line), but wb_ack_o is suppressed in that cycle.
- Back-to-back: a request with stb held high in the cycle after ack is accepted as a new request (IDLE samples it).
- Simultaneous request and reset: reset wins.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..WR_REQ)
  - LINE_WORDS = 1<<LINE_WORDS_LOG2
  - BURST_SIZE constant
- One sub-module: the existing dpram_generic, ADDR_WIDTH=LINE_WORDS_LOG2.
  - Port a: Wishbone read path plus hit-write byte update (we_a = sel).
  - Port b: fill writes (we_b = 4'hF, addr_b = beat counter).
  - Both ports are clocked by wb_clk_i.

Test Plan:
- Cold read miss:
  - Stimulus: read 0x0000_1004; local_ready after 2 cycles; 8 beats 0xA0..0xA7, one per cycle.
  - Required: exactly one read_req with local_address 0x400 and size 8; wb_dat_o=0xA1; ack 3 cycles after beat 7.
- Read hit:
  - Stimulus: after the fill, read 0x0000_101C.
  - Required: no local request; ack at N+2 with data 0xA7.
- Write hit:
  - Stimulus: write 0x0000_1008, sel=4'b0011, data 0x1234_5678; local_ready immediately.
  - Required: write_req, local_be=0x3, local_address=0x402, ack the next cycle.
  - Follow-up: a read of 0x0000_1008 returns 0x0000_5678 | (0xA2 & 0xFFFF_0000) = 0x0000_5678, with no fill.
- Write miss, then read of the same address:
  - Stimulus: write 0x0000_2000 = 0xDEAD_BEEF, then read 0x0000_2000.
  - Required: write issued; line stays on tag 0x1000; the read triggers a fill at 0x800.
- Gapped beats and cyc drop:
  - Stimulus: during a fill, drop wb_cyc_i, with beats 2 idle cycles apart.
  - Required: all 8 beats are stored; no ack; a subsequent read of the same line hits.
- Reset mid-fill:
  - Stimulus: assert wb_rst_i after beat 3.
  - Required: all outputs 0 next cycle; the next read of the same line issues a new fill.
